// File: rtl/mxn_deserializer.sv
// mxn_deserializer: packs up to N M-bit input words into one M*N-bit output word, LSB-first
module mxn_deserializer #(
  parameter int M = 3,
  parameter int N = 4,
  localparam int KW = $clog2(N),
  localparam int CW = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M-1:0]   in_data,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M*N-1:0] out_data,
  output logic [CW-1:0]  out_count
);
  logic [M*(N-1)-1:0] acc_q, acc_d;
  logic [KW-1:0]      cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [M*N-1:0]     out_data_q, out_data_d;
  logic [CW-1:0]      out_count_q, out_count_d;
  logic               accept, done;
  logic [M*N-1:0]     merged;
  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign done      = accept && (cnt_q == KW'(N - 1) || in_last);
  // slots at and above cnt are always zero in the accumulator, so OR-ing the shifted word places it in slot cnt
  assign merged    = {{M{1'b0}}, acc_q} | ({{M*(N-1){1'b0}}, in_data} << (M * int'(cnt_q)));
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  // next-state: accumulate, complete a group, or hold under backpressure
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    if (done) begin
      out_data_d  = merged;
      out_count_d = CW'(cnt_q) + CW'(1);
      out_valid_d = 1'b1;
      cnt_d       = '0;
      acc_d       = '0;
    end else if (accept) begin
      acc_d = merged[M*(N-1)-1:0];
      cnt_d = cnt_q + KW'(1);
    end
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end
endmodule

// File: tb/tb_mxn_deserializer.sv
// tb_mxn_deserializer: directed and randomized checks against a group-list reference model
module tb_mxn_deserializer;
  localparam int M = 3;
  localparam int N = 4;
  localparam int CW = $clog2(N + 1);
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [M-1:0]   in_data = '0;
  logic           in_last = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [M*N-1:0] out_data;
  logic [CW-1:0]  out_count;
  int n_cmp = 0;
  int n_err = 0;
  logic [M-1:0]   grp[$];
  logic           m_ov = 1'b0;
  logic [M*N-1:0] m_data = '0;
  int             m_count = 0;
  int             m_xfers = 0;
  mxn_deserializer #(.M(M), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [M*N-1:0] pack(input int n);
    logic [M*N-1:0] w = '0;
    for (int k = 0; k < n; k++) w = w | ((M*N)'(grp[k]) << (k * M));
    return w;
  endfunction
  task automatic cyc(input logic v, input logic [M-1:0] d, input logic l, input logic r);
    logic exp_ready;
    logic completed;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    exp_ready = !m_ov || r;
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_count", 32'(out_count), 32'(m_count));
    end
    @(posedge clk);
    if (!rst_n) begin
      grp.delete();
      m_ov = 1'b0;
      m_data = '0;
      m_count = 0;
    end else begin
      completed = 1'b0;
      if (m_ov && r) m_xfers++;
      if (v && exp_ready) begin
        grp.push_back(d);
        if (grp.size() == N || l) begin
          m_data = pack(grp.size());
          m_count = grp.size();
          grp.delete();
          completed = 1'b1;
        end
      end
      m_ov = completed || (m_ov && !r);
    end
    #1;
  endtask
  initial begin
    int xf;
    rst_n = 1'b0;
    cyc(1, 3'd5, 1, 1);
    cyc(0, 0, 0, 1);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_count", 32'(out_count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) cyc(1, 3'(i), 0, 1);
    chk("full_data", 32'(out_data), 32'h8D1);
    chk("full_count", 32'(out_count), 4);
    cyc(1, 3'd5, 0, 1);
    cyc(1, 3'd6, 1, 1);
    chk("partial_data", 32'(out_data), 32'h035);
    chk("partial_count", 32'(out_count), 2);
    cyc(1, 3'd7, 1, 1);
    chk("single_data", 32'(out_data), 32'h007);
    chk("single_count", 32'(out_count), 1);
    cyc(0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) cyc(1, 3'(i), 0, 0);
    xf = m_xfers;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 3'(i + 2), i[0], 0);
      chk("bp_hold", 32'(out_data), 32'h8D1);
    end
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("bp_one_xfer", 32'(m_xfers - xf), 1);
    chk("bp_drained", 32'(out_valid), 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 3'(i), 0, 1);
      if (i == 3) chk("stream_w0", 32'(out_data), 32'h688);
      if (i == 7) chk("stream_w1", 32'(out_data), 32'hFAC);
    end
    cyc(0, 0, 0, 1);
    cyc(1, 3'd1, 0, 1);
    cyc(1, 3'd2, 0, 1);
    rst_n = 1'b0;
    cyc(1, 3'd7, 1, 1);
    rst_n = 1'b1;
    chk("rst_mid_valid", 32'(out_valid), 0);
    for (int i = 3; i <= 6; i++) begin
      cyc(1, 3'(i), 0, 1);
      if (i < 6) chk("rst_mid_quiet", 32'(out_valid), 0);
    end
    chk("rst_mid_count", 32'(out_count), 4);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      cyc(($urandom_range(0, 3) != 0), 3'($urandom), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) != 0));
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
